// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared constants for the SPI-attached register bank.
//   Register address map, CTRL LOCK bit index, IRQ_STAT lock-violation
//   bit index and the default identification value read at ADDR_ID.
package reg_bank_pkg;
   localparam int ADDR_CTRL     = 0;
   localparam int ADDR_CFG0     = 1;
   localparam int ADDR_CFG1     = 2;
   localparam int ADDR_CFG2     = 3;
   localparam int ADDR_CFG3     = 4;
   localparam int ADDR_IRQ_MASK = 5;
   localparam int ADDR_IRQ_STAT = 6;
   localparam int ADDR_ID       = 7;
   localparam int NUM_CFG       = 4;

   localparam int LOCK_BIT      = 7;   // CTRL: sticky lock
   localparam int LOCKVIOL_BIT  = 7;   // IRQ_STAT: write attempted while locked

   localparam logic [7:0] DEFAULT_ID = 8'hA5;
endpackage

// File: rtl/reg_bank_if.sv
// reg_bank_if: register access bus between the SPI slave and reg_bank.
//   reg_addr    - register address
//   reg_data_i  - write data
//   reg_data_dv - one-cycle write strobe
//   reg_data_o  - combinational read data for reg_addr
//   master: SPI slave side, slave: register bank side.
interface reg_bank_if #(
   parameter int ADDR_W = 3,
   parameter int REG_W  = 8
);
   logic [ADDR_W-1:0] reg_addr;
   logic [REG_W-1:0]  reg_data_i;
   logic              reg_data_dv;
   logic [REG_W-1:0]  reg_data_o;

   modport master (output reg_addr, reg_data_i, reg_data_dv, input reg_data_o);
   modport slave  (input reg_addr, reg_data_i, reg_data_dv, output reg_data_o);
endinterface

// File: rtl/reg_bank_irq_ctrl.sv
// irq_ctrl: IRQ_STAT register with set-over-clear priority and the
//   registered interrupt request.
//   clk, rstb, ena - clock, async active-low reset, clock enable
//   evt_i          - event pulses setting IRQ_STAT[6:0]
//   lock_viol      - sets IRQ_STAT[LOCKVIOL_BIT]
//   w1c_en/w1c_data- write-one-to-clear access to IRQ_STAT
//   irq_mask       - IRQ_MASK register
//   irq_stat       - IRQ_STAT register
//   irq_o          - registered |(IRQ_STAT & IRQ_MASK)
module irq_ctrl
   import reg_bank_pkg::*;
(
   input  logic       clk,
   input  logic       rstb,
   input  logic       ena,
   input  logic [6:0] evt_i,
   input  logic       lock_viol,
   input  logic       w1c_en,
   input  logic [7:0] w1c_data,
   input  logic [7:0] irq_mask,
   output logic [7:0] irq_stat,
   output logic       irq_o
);
   logic [7:0] set_bits, clr_bits;

   always_comb begin
      set_bits               = {1'b0, evt_i};
      set_bits[LOCKVIOL_BIT] = set_bits[LOCKVIOL_BIT] | lock_viol;
      clr_bits               = w1c_en ? w1c_data : 8'h00;
   end

   // Clear is applied first so a same-cycle set always survives.
   // irq_o samples the current status, hence one cycle behind it.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         irq_stat <= '0;
         irq_o    <= 1'b0;
      end else if (ena) begin
         irq_stat <= (irq_stat & ~clr_bits) | set_bits;
         irq_o    <= |(irq_stat & irq_mask);
      end
   end
endmodule

// File: rtl/reg_bank.sv
// reg_bank: 8-entry register bank behind an SPI slave.
//   clk, rstb   - clock, async active-low reset
//   ena         - clock enable, all state holds when low
//   bus         - register access bus (reg_bank_if.slave)
//   evt_i       - event pulses into IRQ_STAT[6:0]
//   ctrl_o      - CTRL register
//   cfg_o       - {CFG3, CFG2, CFG1, CFG0}
//   wr_strobe_o - one-hot, one-cycle pulse per accepted write
//   irq_o       - registered interrupt request
//   status_o    - {LOCK, irq_o, |IRQ_STAT, 5'b0}
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int               ADDR_W   = 3,
   parameter int               REG_W    = 8,
   parameter logic [REG_W-1:0] ID_VALUE = REG_W'(DEFAULT_ID)
) (
   input  logic                   clk,
   input  logic                   rstb,
   input  logic                   ena,
   reg_bank_if.slave              bus,
   input  logic [6:0]             evt_i,
   output logic [7:0]             ctrl_o,
   output logic [4*REG_W-1:0]     cfg_o,
   output logic [7:0]             wr_strobe_o,
   output logic                   irq_o,
   output logic [7:0]             status_o
);
   logic [7:0]                     ctrl, irq_mask, irq_stat;
   logic [NUM_CFG-1:0][REG_W-1:0]  cfg;
   logic [7:0]                     wr_sel, wr_acc;
   logic                           locked, lock_viol;

   assign locked = ctrl[LOCK_BIT];

   // Address decode of an enabled write strobe.
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < 8; i++)
         wr_sel[i] = ena && bus.reg_data_dv && (bus.reg_addr == ADDR_W'(i));
   end

   // ID is read-only; CFG0..IRQ_MASK are frozen while locked.
   always_comb begin
      wr_acc          = wr_sel;
      wr_acc[ADDR_ID] = 1'b0;
      if (locked)
         wr_acc[ADDR_IRQ_MASK:ADDR_CFG0] = '0;
   end

   assign lock_viol = locked && (|wr_sel[ADDR_IRQ_MASK:ADDR_CFG0]);

   // wr_strobe_o is a pulse: it always reloads (wr_acc is 0 with ena low)
   // so it can never stretch across a disabled cycle.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         ctrl        <= '0;
         cfg         <= '0;
         irq_mask    <= '0;
         wr_strobe_o <= '0;
      end else begin
         wr_strobe_o <= wr_acc;
         if (wr_acc[ADDR_CTRL])
            ctrl <= bus.reg_data_i[7:0] | {ctrl[LOCK_BIT], 7'b0};
         for (int i = 0; i < NUM_CFG; i++)
            if (wr_acc[ADDR_CFG0+i]) cfg[i] <= bus.reg_data_i;
         if (wr_acc[ADDR_IRQ_MASK])
            irq_mask <= bus.reg_data_i[7:0];
      end
   end

   irq_ctrl u_irq_ctrl (
      .clk       (clk),
      .rstb      (rstb),
      .ena       (ena),
      .evt_i     (evt_i),
      .lock_viol (lock_viol),
      .w1c_en    (wr_acc[ADDR_IRQ_STAT]),
      .w1c_data  (bus.reg_data_i[7:0]),
      .irq_mask  (irq_mask),
      .irq_stat  (irq_stat),
      .irq_o     (irq_o)
   );

   always_comb begin
      bus.reg_data_o = '0;
      case (int'(bus.reg_addr))
         ADDR_CTRL:     bus.reg_data_o = REG_W'(ctrl);
         ADDR_CFG0:     bus.reg_data_o = cfg[0];
         ADDR_CFG1:     bus.reg_data_o = cfg[1];
         ADDR_CFG2:     bus.reg_data_o = cfg[2];
         ADDR_CFG3:     bus.reg_data_o = cfg[3];
         ADDR_IRQ_MASK: bus.reg_data_o = REG_W'(irq_mask);
         ADDR_IRQ_STAT: bus.reg_data_o = REG_W'(irq_stat);
         ADDR_ID:       bus.reg_data_o = ID_VALUE;
         default:       bus.reg_data_o = '0;
      endcase
   end

   assign ctrl_o   = ctrl;
   assign cfg_o    = cfg;
   assign status_o = {locked, irq_o, |irq_stat, 5'b0};
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed bench for reg_bank with a register-map model
//   checked against the DUT on every falling clock edge.
module tb_reg_bank;
   logic       clk = 1'b0;
   logic       rstb = 1'b0;
   logic       ena = 1'b1;
   logic [6:0] evt_i = '0;
   logic [7:0] ctrl_o, wr_strobe_o, status_o;
   logic [31:0] cfg_o;
   logic       irq_o;

   int n_tests = 0;
   int n_fail  = 0;

   reg_bank_if #(.ADDR_W(3), .REG_W(8)) bus ();

   reg_bank dut (
      .clk         (clk),
      .rstb        (rstb),
      .ena         (ena),
      .bus         (bus),
      .evt_i       (evt_i),
      .ctrl_o      (ctrl_o),
      .cfg_o       (cfg_o),
      .wr_strobe_o (wr_strobe_o),
      .irq_o       (irq_o),
      .status_o    (status_o)
   );

   always #5 clk = ~clk;

   // ---------------- model: register map as plain variables ----------------
   logic [7:0] m_ctrl = '0, m_mask = '0, m_stat = '0, m_strobe = '0;
   logic [7:0] m_cfg [4] = '{default: 8'h00};
   logic       m_irq = 1'b0;
   logic [7:0] nstat, d;
   int         a;

   function automatic logic [7:0] m_read(input int ad);
      case (ad)
         0:       return m_ctrl;
         1,2,3,4: return m_cfg[ad-1];
         5:       return m_mask;
         6:       return m_stat;
         default: return 8'hA5;
      endcase
   endfunction

   always @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         m_ctrl = '0; m_mask = '0; m_stat = '0; m_strobe = '0; m_irq = 1'b0;
         for (int i = 0; i < 4; i++) m_cfg[i] = '0;
      end else begin
         m_strobe = '0;
         if (ena) begin
            m_irq = |(m_stat & m_mask);
            nstat = m_stat;
            a = int'(bus.reg_addr);
            d = bus.reg_data_i;
            if (bus.reg_data_dv) begin
               if (a == 0) begin
                  m_ctrl = {m_ctrl[7] | d[7], d[6:0]};
                  m_strobe[0] = 1'b1;
               end else if (a >= 1 && a <= 5) begin
                  if (m_ctrl[7]) nstat[7] = 1'b1;
                  else begin
                     if (a == 5) m_mask = d; else m_cfg[a-1] = d;
                     m_strobe[a] = 1'b1;
                  end
               end else if (a == 6) begin
                  nstat = nstat & ~d;
                  m_strobe[6] = 1'b1;
               end
            end
            m_stat = nstat | {1'b0, evt_i} | {m_ctrl[7] && bus.reg_data_dv && a >= 1 && a <= 5, 7'b0};
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cmp_rdata",  bus.reg_data_o, m_read(int'(bus.reg_addr)));
      chk("cmp_ctrl",   ctrl_o, m_ctrl);
      chk("cmp_cfg",    cfg_o, {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]});
      chk("cmp_strobe", wr_strobe_o, m_strobe);
      chk("cmp_irq",    irq_o, m_irq);
      chk("cmp_status", status_o, {m_ctrl[7], m_irq, |m_stat, 5'b0});
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic wr(input int ad, input logic [7:0] dv);
      bus.reg_addr = 3'(ad); bus.reg_data_i = dv; bus.reg_data_dv = 1'b1;
      cyc();
      bus.reg_data_dv = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input int ad, input logic [7:0] exp);
      bus.reg_addr = 3'(ad); #1;
      chk(nm, bus.reg_data_o, exp);
   endtask

   initial begin
      bus.reg_addr = '0; bus.reg_data_i = '0; bus.reg_data_dv = 1'b0;
      cyc(); cyc();
      chk("rst_ctrl", ctrl_o, 8'h00);
      chk("rst_irq", irq_o, 1'b0);
      rstb = 1'b1;
      cyc();
      rd_chk("rst_rd0", 0, 8'h00);
      rd_chk("rst_id", 7, 8'hA5);

      // Basic CFG write with strobe
      wr(2, 8'h3C);
      chk("w2_strobe", wr_strobe_o, 8'b0000_0100);
      chk("w2_cfg1", cfg_o[15:8], 8'h3C);
      rd_chk("w2_rd", 2, 8'h3C);
      cyc();
      chk("w2_strobe_gone", wr_strobe_o, 8'h00);

      // Event -> status -> irq, then W1C
      wr(5, 8'h01);
      evt_i = 7'h01; cyc(); evt_i = '0;
      rd_chk("evt_stat", 6, 8'h01);
      chk("evt_irq_lat", irq_o, 1'b0);
      cyc();
      chk("evt_irq", irq_o, 1'b1);
      wr(6, 8'h01);
      rd_chk("w1c_stat", 6, 8'h00);
      chk("w1c_irq_lat", irq_o, 1'b1);
      cyc();
      chk("w1c_irq", irq_o, 1'b0);

      // Set beats clear on the same bit
      evt_i = 7'h04; wr(6, 8'h04); evt_i = '0;
      rd_chk("setwin_stat", 6, 8'h04);
      wr(6, 8'h04);
      rd_chk("setwin_clr", 6, 8'h00);

      // ID is read-only; ena low blocks writes
      wr(7, 8'hFF);
      chk("id_strobe", wr_strobe_o, 8'h00);
      rd_chk("id_rd", 7, 8'hA5);
      ena = 1'b0; wr(2, 8'h77);
      chk("ena_cfg1", cfg_o[15:8], 8'h3C);
      chk("ena_strobe", wr_strobe_o, 8'h00);
      ena = 1'b1;

      // Lock behaviour
      wr(0, 8'h80);
      wr(1, 8'h11);
      chk("lock_strobe", wr_strobe_o, 8'h00);
      wr(0, 8'h00);
      chk("lock_ctrl", ctrl_o, 8'h80);
      chk("lock_cfg0", cfg_o[7:0], 8'h00);
      rd_chk("lock_stat", 6, 8'h80);
      chk("lock_status", status_o, 8'hA0);
      wr(0, 8'h05);
      chk("lock_low_bits", ctrl_o, 8'h85);
      wr(5, 8'hFF);
      rd_chk("lock_mask", 5, 8'h01);

      // Reset right after a write is taken
      bus.reg_addr = 3'd3; bus.reg_data_i = 8'h55; bus.reg_data_dv = 1'b1;
      cyc();
      rstb = 1'b0; bus.reg_data_dv = 1'b0; #1;
      chk("rst_mid_cfg2", cfg_o[23:16], 8'h00);
      chk("rst_mid_strobe", wr_strobe_o, 8'h00);
      cyc(); rstb = 1'b1;
      cyc();
      chk("rst_rel_strobe", wr_strobe_o, 8'h00);
      rd_chk("rst_rel_cfg2", 3, 8'h00);
      chk("rst_rel_ctrl", ctrl_o, 8'h00);
      cyc(); cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, register address width (8 registers).
REQ-002 SHALL have parameter REG_W, default 8, register data width.
REQ-003 SHALL have parameter ID_VALUE, default 8'hA5, read-only identification value at address 7.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rstb  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ena  input  1  clock enable; when low, all state holds.
REQ-007 SHALL have port reg_addr  input  ADDR_W  register address from the SPI slave.
REQ-008 SHALL have port reg_data_i  input  REG_W  write data from the SPI slave.
REQ-009 SHALL have port reg_data_dv  input  1  one-cycle write strobe from the SPI slave.
REQ-010 SHALL have port reg_data_o  output  REG_W  read data for the addressed register, returned to the SPI slave.
REQ-011 SHALL have port evt_i  input  7  synchronous active-high event pulses.
REQ-012 SHALL have port ctrl_o  output  8  CTRL register contents.
REQ-013 SHALL have port cfg_o  output  4*REG_W  CFG0..CFG3 concatenated, with CFG0 in the LSBs.
REQ-014 SHALL have port wr_strobe_o  output  8  one-hot pulse marking an accepted write per address.
REQ-015 SHALL have port irq_o  output  1  registered interrupt request.
REQ-016 SHALL have port status_o  output  8  status byte for the SPI slave's status input.

Function
REQ-017 Register map SHALL be: 0 CTRL RW; 1-4 CFG0-CFG3 RW; 5 IRQ_MASK RW; 6 IRQ_STAT W1C; 7 ID RO.
REQ-018 A write SHALL be accepted when ena=1 and reg_data_dv=1, and SHALL update the target on that clock edge.
REQ-019 reg_data_o SHALL be a combinational mux of stored register values, valid in the same cycle as reg_addr.
REQ-020 CTRL bit 7 (LOCK) SHALL be sticky: a write of 1 sets it, a write of 0 does not clear it, and only reset clears it.
REQ-021 CTRL bits 6:0 SHALL remain writable while LOCK=1.
REQ-022 While LOCK=1, writes to addresses 1-5 SHALL be discarded and SHALL set IRQ_STAT bit 7 (lock violation).
REQ-023 Writes to address 7 SHALL be ignored with no side effects.
REQ-024 IRQ_STAT bits 6:0 SHALL set when the corresponding evt_i bit is 1 with ena=1.
REQ-025 Writing 1 to an IRQ_STAT bit SHALL clear it; writing 0 SHALL leave it unchanged.
REQ-026 When an event set and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-027 A lock violation and a W1C clear of bit 7 in the same cycle SHALL leave bit 7 set.
REQ-028 wr_strobe_o[a] SHALL pulse for exactly one cycle, one cycle after an accepted write to address a.
REQ-029 Discarded writes (locked, or address 7) SHALL produce no wr_strobe_o pulse.
REQ-030 irq_o SHALL be registered as |(IRQ_STAT & IRQ_MASK), giving one cycle of latency after the status change.
REQ-031 status_o SHALL equal {LOCK, irq_o, |IRQ_STAT, 5'b0}.

Reset
REQ-032 On rstb low, CTRL, CFG0-3, IRQ_MASK, IRQ_STAT, wr_strobe_o and irq_o SHALL all be 0 asynchronously.
REQ-033 A reset asserted mid-write SHALL discard the write with no strobe afterwards.
REQ-034 After reset, reg_data_o SHALL read 0 for addresses 0-6 and ID_VALUE for address 7.

Structure
REQ-035 A shared package SHALL hold the register address constants (ADDR_CTRL..ADDR_ID), the LOCK bit index, the LOCKVIOL bit index and the default ID value.
REQ-036 There SHALL be one sub-module, irq_ctrl, holding IRQ_STAT set/W1C priority and the irq_o register; register storage and decode SHALL stay in reg_bank.

Verification
REQ-037 Write 8'h3C to address 2, then read address 2: reg_data_o=8'h3C, cfg_o[15:8]=8'h3C, wr_strobe_o=8'b0000_0100 for one cycle.
REQ-038 Write 8'h80 to address 0, write 8'h11 to address 1, write 8'h00 to address 0: CFG0 stays 0, IRQ_STAT=8'h80, ctrl_o[7]=1, status_o[7]=1.
REQ-039 Set IRQ_MASK=8'h01, pulse evt_i=7'h01: IRQ_STAT=8'h01 next cycle, irq_o=1 one cycle later; write 8'h01 to address 6: IRQ_STAT=0, irq_o=0 one cycle later.
REQ-040 Pulse evt_i[2] in the same cycle as a W1C write of 8'h04 to address 6: IRQ_STAT bit 2 remains 1.
REQ-041 Write 8'hFF to address 7 with ena=1, then any write with ena=0: reads unchanged (address 7 still 8'hA5), no wr_strobe_o pulse.
REQ-042 Assert rstb low one cycle after reg_data_dv for a write of 8'h55 to address 3: CFG2=0, no strobe after reset release.
